reg_rr_arb: RTL and testbench

//   Round-robin arbiter sharing one register-interface target between NoPorts requesters.

---
 rtl/reg_rr_arb.sv | 171 +++++++++++++++++
 tb/tb_reg_rr_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rr_arb.sv
// reg_rr_arb_pkg / reg_rr_arb
//
// Round-robin arbiter that shares one register-interface target between
// NoPorts requesters. The winner is chosen combinationally and sees the target
// in the same cycle. If the target does not answer at once, the grant is held
// until the transfer completes. Only the granted port receives the response.
// Every other port receives an all-zero response.
//
// Parameters
//   NoPorts      number of requester ports (>= 1)
//   req_t        request struct  {addr, write, wdata, wstrb, valid}
//   rsp_t        response struct {rdata, error, ready}
//   SelectWidth  width of the grant index (derived, do not override)
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   in_req_i     requests from the masters
//   in_rsp_o     responses to the masters
//   out_req_o    request to the shared target
//   out_rsp_i    response from the shared target
//   gnt_idx_o    index of the current, or last, granted port
//   busy_o       high while the grant is locked on a stalled transfer

package reg_rr_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module reg_rr_arb #(
    parameter int  NoPorts     = 2,
    parameter type req_t       = reg_rr_arb_pkg::reg_req_t,
    parameter type rsp_t       = reg_rr_arb_pkg::reg_rsp_t,
    parameter int  SelectWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  req_t                   in_req_i [NoPorts],
    output rsp_t                   in_rsp_o [NoPorts],
    output req_t                   out_req_o,
    input  rsp_t                   out_rsp_i,
    output logic [SelectWidth-1:0] gnt_idx_o,
    output logic                   busy_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q;
    logic [SelectWidth-1:0] prio_q;
    logic [SelectWidth-1:0] lock_q;
    logic [SelectWidth-1:0] last_gnt_q;

    logic                   any_valid;
    logic [SelectWidth-1:0] winner;
    logic [SelectWidth-1:0] sel;
    logic                   route_en;
    logic                   handshake;
    logic [NoPorts-1:0]     rsp_ready_vec;

    // The port index wraps at NoPorts-1. It does not wrap at
    // 2^SelectWidth-1, so port counts that are not a power of two rotate
    // correctly.
    function automatic logic [SelectWidth-1:0] wrap_add(
        input logic [SelectWidth-1:0] base,
        input int                     off
    );
        int s;
        s = int'(base) + off;
        if (s >= NoPorts) begin
            s = s - NoPorts;
        end
        return SelectWidth'(s);
    endfunction

    // The winner is the first valid port, searching upward from prio_q.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int off = 0; off < NoPorts; off++) begin
            if (!any_valid && in_req_i[wrap_add(prio_q, off)].valid) begin
                any_valid = 1'b1;
                winner    = wrap_add(prio_q, off);
            end
        end
    end

    // In BUSY the locked port owns the target. In IDLE the fresh winner owns
    // it. With nothing to route, the target and all masters see all-zero
    // traffic.
    always_comb begin
        sel       = (state_q == BUSY) ? lock_q : winner;
        route_en  = (state_q == BUSY) || any_valid;
        out_req_o = route_en ? in_req_i[sel] : '0;
        for (int i = 0; i < NoPorts; i++) begin
            in_rsp_o[i]      = (route_en && (sel == SelectWidth'(i))) ? out_rsp_i : '0;
            rsp_ready_vec[i] = in_rsp_o[i].ready;
        end
        handshake = out_req_o.valid && out_rsp_i.ready;
        if (state_q == BUSY) begin
            gnt_idx_o = lock_q;
        end else if (any_valid) begin
            gnt_idx_o = winner;
        end else begin
            gnt_idx_o = last_gnt_q;
        end
    end

    assign busy_o = (state_q == BUSY);

    // A transfer that completes in its first cycle only advances the
    // priority. A stalled transfer locks the grant until ready arrives. If the
    // locked master drops valid, the arbiter abandons the lock and does not
    // rotate the priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prio_q     <= '0;
            lock_q     <= '0;
            last_gnt_q <= '0;
        end else begin
            last_gnt_q <= gnt_idx_o;
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        if (handshake) begin
                            prio_q <= wrap_add(winner, 1);
                        end else begin
                            lock_q  <= winner;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!in_req_i[lock_q].valid) begin
                        state_q <= IDLE;
                    end else if (out_rsp_i.ready) begin
                        prio_q  <= wrap_add(lock_q, 1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_ready_vec));

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (busy_o && !out_rsp_i.ready) |=> $stable(out_req_o));

    a_gnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(gnt_idx_o) < NoPorts);

    a_lock_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o |-> in_req_i[lock_q].valid);

endmodule

// File: tb/tb_reg_rr_arb.sv
// tb_reg_rr_arb
//
// Bench for reg_rr_arb. It uses two instances:
//   dut4 (NoPorts=4) is checked on every cycle against a behavioural
//   round-robin model and also by directed literal checks.
//   dut3 (NoPorts=3) uses directed literal checks to exercise the modulo-3
//   priority wrap.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.

module tb_reg_rr_arb;
    import reg_rr_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;

    reg_req_t   req4 [4];
    reg_rsp_t   rsp4 [4];
    reg_req_t   out_req4;
    reg_rsp_t   trsp4;
    logic [1:0] gnt4;
    logic       busy4;

    reg_req_t   req3 [3];
    reg_rsp_t   rsp3 [3];
    reg_req_t   out_req3;
    reg_rsp_t   trsp3;
    logic [1:0] gnt3;
    logic       busy3;

    int tests    = 0;
    int failures = 0;

    int m_prio   = 0;
    int m_holder = -1;
    int m_last   = 0;

    always #5 clk = ~clk;

    reg_rr_arb #(.NoPorts(4)) dut4 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_req_i  (req4),
        .in_rsp_o  (rsp4),
        .out_req_o (out_req4),
        .out_rsp_i (trsp4),
        .gnt_idx_o (gnt4),
        .busy_o    (busy4)
    );

    reg_rr_arb #(.NoPorts(3)) dut3 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_req_i  (req3),
        .in_rsp_o  (rsp3),
        .out_req_o (out_req3),
        .out_rsp_i (trsp3),
        .gnt_idx_o (gnt3),
        .busy_o    (busy3)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic reg_rsp_t mk_rsp(input logic rdy, input logic [31:0] rd, input logic err);
        reg_rsp_t r;
        r.rdata = rd;
        r.error = err;
        r.ready = rdy;
        return r;
    endfunction

    task automatic applyStimulus(input logic rst_v, input logic [3:0] v4, input reg_rsp_t r4,
                                 input logic [2:0] v3, input reg_rsp_t r3);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        for (int i = 0; i < 4; i++) req4[i].valid = v4[i];
        for (int i = 0; i < 3; i++) req3[i].valid = v3[i];
        trsp4 = r4;
        trsp3 = r3;
        @(negedge clk);
    endtask

    // Round-robin model for dut4. m_holder is -1 when no master holds the
    // target, otherwise it is the port that owns the stalled transfer.
    always @(negedge clk) begin
        int       win;
        int       sel;
        reg_req_t exp_req;
        logic     xfer;
        if (!rst_n) begin
            m_prio   = 0;
            m_holder = -1;
            m_last   = 0;
        end
        win = -1;
        for (int k = 0; k < 4; k++) begin
            if (win < 0 && req4[(m_prio + k) % 4].valid) win = (m_prio + k) % 4;
        end
        sel     = (m_holder >= 0) ? m_holder : win;
        exp_req = (sel >= 0) ? req4[sel] : '0;
        checkOutput("model_out_req", 128'(out_req4), 128'(exp_req));
        checkOutput("model_gnt", 128'(gnt4), (sel >= 0) ? 128'(sel) : 128'(m_last));
        checkOutput("model_busy", 128'(busy4), 128'(m_holder >= 0));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("model_in_rsp[%0d]", i), 128'(rsp4[i]),
                        (i == sel) ? 128'(trsp4) : 128'(0));
        end
        if (rst_n) begin
            xfer = (sel >= 0) && exp_req.valid && trsp4.ready;
            if (sel >= 0) m_last = sel;
            if (m_holder >= 0) begin
                if (!req4[m_holder].valid) begin
                    m_holder = -1;
                end else if (xfer) begin
                    m_prio   = (m_holder + 1) % 4;
                    m_holder = -1;
                end
            end else if (win >= 0) begin
                if (xfer) m_prio = (win + 1) % 4;
                else      m_holder = win;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reg_rsp_t z;
        reg_rsp_t rdy;
        z   = mk_rsp(1'b0, 32'h0, 1'b0);
        rdy = mk_rsp(1'b1, 32'h0, 1'b0);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req4[i].addr  = 32'h100 + 32'(4 * i);
            req4[i].write = 1'b1;
            req4[i].wdata = 32'h1000 + 32'(i);
            req4[i].wstrb = 4'hF;
            req4[i].valid = 1'b0;
        end
        req4[1].addr  = 32'h10;
        req4[1].wdata = 32'hDEAD;
        req4[3].write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req3[i].addr  = 32'h200 + 32'(4 * i);
            req3[i].write = 1'b0;
            req3[i].wdata = 32'h0;
            req3[i].wstrb = 4'h0;
            req3[i].valid = 1'b0;
        end
        trsp4 = z;
        trsp3 = z;
        #2 rst_n = 1'b0;

        // Reset with no requests active.
        applyStimulus(1'b0, 4'b0000, z, 3'b000, z);
        checkOutput("rst_out_valid", 128'(out_req4.valid), 128'(0));
        checkOutput("rst_busy", 128'(busy4), 128'(0));
        checkOutput("rst_gnt", 128'(gnt4), 128'(0));
        for (int i = 0; i < 4; i++) checkOutput("rst_ready", 128'(rsp4[i].ready), 128'(0));
        applyStimulus(1'b1, 4'b0000, z, 3'b000, z);
        checkOutput("idle_gnt", 128'(gnt4), 128'(0));

        // All four ports request on every cycle and the target is always
        // ready.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 4'b1111, rdy, 3'b000, z);
            checkOutput("rr_gnt", 128'(gnt4), 128'(k % 4));
            checkOutput("rr_ready", 128'(rsp4[k % 4].ready), 128'(1));
            checkOutput("rr_busy", 128'(busy4), 128'(0));
        end

        // Port 1 write while the target stalls. Port 2 requests meanwhile.
        applyStimulus(1'b1, 4'b0010, z, 3'b000, z);
        checkOutput("stall_gnt", 128'(gnt4), 128'(1));
        checkOutput("stall_busy0", 128'(busy4), 128'(0));
        checkOutput("stall_req", 128'(out_req4), 128'({32'h10, 1'b1, 32'hDEAD, 4'hF, 1'b1}));
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 4'b0110, (k == 3) ? rdy : z, 3'b000, z);
            checkOutput("stall_busy", 128'(busy4), 128'(1));
            checkOutput("stall_lock_gnt", 128'(gnt4), 128'(1));
            checkOutput("stall_p2_ready", 128'(rsp4[2].ready), 128'(0));
            checkOutput("stall_p1_ready", 128'(rsp4[1].ready), 128'(k == 3));
        end
        applyStimulus(1'b1, 4'b0100, rdy, 3'b000, z);
        checkOutput("after_stall_gnt", 128'(gnt4), 128'(2));
        checkOutput("after_stall_busy", 128'(busy4), 128'(0));

        // Port 3 read returns rdata together with an error.
        applyStimulus(1'b1, 4'b1000, mk_rsp(1'b1, 32'hCAFE, 1'b1), 3'b000, z);
        checkOutput("err_gnt", 128'(gnt4), 128'(3));
        checkOutput("err_rsp3", 128'(rsp4[3]), 128'({32'hCAFE, 1'b1, 1'b1}));
        for (int i = 0; i < 3; i++) checkOutput("err_rsp_other", 128'(rsp4[i]), 128'(0));
        applyStimulus(1'b1, 4'b0000, z, 3'b000, z);
        checkOutput("hold_gnt", 128'(gnt4), 128'(3));
        checkOutput("hold_out_valid", 128'(out_req4.valid), 128'(0));

        // Rotate the priority to port 1, lock port 3, then reset mid-stall.
        applyStimulus(1'b1, 4'b0001, rdy, 3'b000, z);
        checkOutput("pre_rst_gnt0", 128'(gnt4), 128'(0));
        applyStimulus(1'b1, 4'b1000, z, 3'b000, z);
        checkOutput("pre_rst_gnt3", 128'(gnt4), 128'(3));
        applyStimulus(1'b1, 4'b1000, z, 3'b000, z);
        checkOutput("pre_rst_busy", 128'(busy4), 128'(1));
        applyStimulus(1'b0, 4'b0000, z, 3'b000, z);
        checkOutput("mid_rst_busy", 128'(busy4), 128'(0));
        checkOutput("mid_rst_gnt", 128'(gnt4), 128'(0));
        checkOutput("mid_rst_valid", 128'(out_req4.valid), 128'(0));
        applyStimulus(1'b1, 4'b0000, z, 3'b000, z);
        applyStimulus(1'b1, 4'b0011, rdy, 3'b000, z);
        checkOutput("post_rst_gnt", 128'(gnt4), 128'(0));
        checkOutput("post_rst_ready0", 128'(rsp4[0].ready), 128'(1));
        applyStimulus(1'b1, 4'b0000, z, 3'b000, z);

        // With three ports the priority wraps from 2 back to 0.
        applyStimulus(1'b1, 4'b0000, z, 3'b100, rdy);
        checkOutput("p3_gnt_a", 128'(gnt3), 128'(2));
        checkOutput("p3_ready2", 128'(rsp3[2].ready), 128'(1));
        checkOutput("p3_busy", 128'(busy3), 128'(0));
        applyStimulus(1'b1, 4'b0000, z, 3'b101, rdy);
        checkOutput("p3_gnt_b", 128'(gnt3), 128'(0));
        checkOutput("p3_ready0", 128'(rsp3[0].ready), 128'(1));
        checkOutput("p3_ready2_off", 128'(rsp3[2].ready), 128'(0));
        applyStimulus(1'b1, 4'b0000, z, 3'b101, rdy);
        checkOutput("p3_gnt_c", 128'(gnt3), 128'(2));
        applyStimulus(1'b1, 4'b0000, z, 3'b111, rdy);
        checkOutput("p3_gnt_d", 128'(gnt3), 128'(0));
        checkOutput("p3_out_addr", 128'(out_req3.addr), 128'(32'h200));
        applyStimulus(1'b1, 4'b0000, z, 3'b000, z);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
